// File: rtl/csr_write_unit.sv
// Machine-mode CSR access unit: three-phase read/modify/write of the M-mode CSR file,
// with trap entry and mret handled alongside any in-flight CSR instruction.
module csr_write_unit #(
  parameter logic [31:0] HART_ID     = 32'h0000_0000,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [11:0] csr_addr,
  input  logic [1:0]  csr_op,
  input  logic [31:0] wdata,
  input  logic        write_en,
  output logic        done,
  output logic [31:0] rdata,
  output logic        illegal,
  input  logic        trap_valid,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_tval,
  input  logic        mret_valid,
  output logic [31:0] trap_vector,
  output logic [31:0] mret_pc,
  output logic        mstatus_mie
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_e;

  state_e      state_q;
  logic [11:0] addr_q;
  logic [1:0]  op_q;
  logic [31:0] wdata_q;
  logic        wen_q;
  logic [31:0] old_q;
  logic        done_q;
  logic [31:0] rdata_q;
  logic        illegal_q;
  logic        mie_bit_q;
  logic        mpie_bit_q;
  logic [31:0] mie_q;
  logic [31:0] mtvec_q;
  logic [31:0] mscratch_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] mtval_q;

  logic [31:0] rd_val_s;
  logic        rd_known_s;
  logic        rd_only_s;
  logic        illegal_s;
  logic [31:0] new_d;
  logic        commit_s;

  // Read mux over the latched address; also classifies the address.
  always_comb begin
    rd_val_s   = 32'h0000_0000;
    rd_known_s = 1'b1;
    rd_only_s  = 1'b0;
    case (addr_q)
      12'hF11, 12'hF12, 12'hF13: rd_only_s = 1'b1;
      12'hF14: begin
        rd_only_s = 1'b1;
        rd_val_s  = HART_ID;
      end
      12'h300: rd_val_s = {19'd0, 2'b11, 3'd0, mpie_bit_q, 3'd0, mie_bit_q, 3'd0};
      12'h301: rd_val_s = 32'h4000_0100;
      12'h304: rd_val_s = mie_q;
      12'h305: rd_val_s = mtvec_q;
      12'h306: rd_val_s = 32'h0000_0000;
      12'h340: rd_val_s = mscratch_q;
      12'h341: rd_val_s = mepc_q;
      12'h342: rd_val_s = mcause_q;
      12'h343: rd_val_s = mtval_q;
      12'h344: rd_val_s = 32'h0000_0000;
      default: rd_known_s = 1'b0;
    endcase
  end

  // Read-modify-write value and the commit qualifier for the WRITE phase.
  always_comb begin
    case (op_q)
      2'b01:   new_d = wdata_q;
      2'b10:   new_d = old_q | wdata_q;
      2'b11:   new_d = old_q & ~wdata_q;
      default: new_d = old_q;
    endcase
    illegal_s = !rd_known_s || (op_q == 2'b00) || (wen_q && rd_only_s);
    commit_s  = (state_q == S_WRITE) && !illegal_s && wen_q && !trap_valid;
  end

  // Request FSM, CSR state, trap entry and mret; trap outranks everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= 12'h000;
      op_q       <= 2'b00;
      wdata_q    <= 32'h0000_0000;
      wen_q      <= 1'b0;
      old_q      <= 32'h0000_0000;
      done_q     <= 1'b0;
      rdata_q    <= 32'h0000_0000;
      illegal_q  <= 1'b0;
      mie_bit_q  <= 1'b0;
      mpie_bit_q <= 1'b0;
      mie_q      <= 32'h0000_0000;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= 32'h0000_0000;
      mepc_q     <= 32'h0000_0000;
      mcause_q   <= 32'h0000_0000;
      mtval_q    <= 32'h0000_0000;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      if (trap_valid) begin
        state_q    <= S_IDLE;
        mepc_q     <= trap_pc & ~32'h0000_0003;
        mcause_q   <= trap_cause;
        mtval_q    <= trap_tval;
        mpie_bit_q <= mie_bit_q;
        mie_bit_q  <= 1'b0;
      end else begin
        // A same-cycle CSR write to mstatus overrides the mret update.
        if (mret_valid && !(commit_s && (addr_q == 12'h300))) begin
          mie_bit_q  <= mpie_bit_q;
          mpie_bit_q <= 1'b1;
        end
        case (state_q)
          S_IDLE: begin
            if (req_valid) begin
              addr_q  <= csr_addr;
              op_q    <= csr_op;
              wdata_q <= wdata;
              wen_q   <= write_en;
              state_q <= S_READ;
            end
          end
          S_READ: begin
            old_q   <= rd_val_s;
            state_q <= S_WRITE;
          end
          S_WRITE: begin
            done_q    <= 1'b1;
            illegal_q <= illegal_s;
            rdata_q   <= illegal_s ? 32'h0000_0000 : old_q;
            state_q   <= S_IDLE;
            if (commit_s) begin
              case (addr_q)
                12'h300: begin
                  mie_bit_q  <= new_d[3];
                  mpie_bit_q <= new_d[7];
                end
                12'h304: mie_q      <= new_d & 32'h0000_0888;
                12'h305: mtvec_q    <= new_d & ~32'h0000_0003;
                12'h340: mscratch_q <= new_d;
                12'h341: mepc_q     <= new_d & ~32'h0000_0003;
                12'h342: mcause_q   <= new_d;
                12'h343: mtval_q    <= new_d;
                default: ;
              endcase
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign done        = done_q;
  assign rdata       = rdata_q;
  assign illegal     = illegal_q;
  assign trap_vector = mtvec_q;
  assign mret_pc     = mepc_q;
  assign mstatus_mie = mie_bit_q;

endmodule
